ps2_key_ascii: RTL
==================

PS2_KEY_ASCII -- requirements
Module: ps2_key_ascii

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, clk cycles without a ps2_clk falling edge before a partial frame is aborted.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for ps2_clk and ps2_data.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock, asynchronous to clk.
REQ-006 ps2_data  input  1  raw PS/2 data, asynchronous to clk.
REQ-007 key_out  output  8  ASCII of last emitted key; feeds display memory key_in.
REQ-008 k_valid  output  1  one-cycle pulse qualifying key_out; feeds display memory p_valid; no backpressure.
REQ-009 frame_err  output  1  one-cycle pulse per discarded frame.
REQ-010 shift_active  output  1  level, a Shift key is currently held.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through SYNC_STAGES flops and detect a falling edge as a registered 1 followed by a synchronised 0.
REQ-012 SHALL sample ps2_data on each detected falling edge into an 11-bit frame: start 0, 8 data bits LSB first, odd parity, stop 1.
REQ-013 SHALL, on the 11th bit, accept the byte only if start=0, stop=1 and parity is odd; otherwise discard it and pulse frame_err.
REQ-014 SHALL abort a partial frame (bit count 1..10) when TIMEOUT_CYCLES elapse without a falling edge, clear the bit count and pulse frame_err.
REQ-015 SHALL pulse the internal byte strobe on the cycle after the stop-bit edge is detected, and register key_out/k_valid on the following cycle (2 cycles total latency).
REQ-016 Decoder FSM states SHALL be IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
REQ-017 IDLE: F0 -> BRK; E0 -> EXT; 0x12 or 0x59 -> set shift, stay IDLE; other code -> translate, emit if mapped, stay IDLE.
REQ-018 BRK: 0x12 or 0x59 clears shift; any code -> IDLE; no emission.
REQ-019 EXT: F0 -> EXT_BRK; 0x5A -> emit 0x0A, IDLE; other codes -> IDLE without emission.
REQ-020 EXT_BRK: any code -> IDLE without emission.
REQ-021 Translation (US layout): letters 0x1C..(set 2) -> a-z, uppercase when shift; digits -> 0-9, shifted -> !@#$%^&*(); 0x29 -> 0x20; 0x5A -> 0x0A; 0x66 -> 0x08; 0x4E, 0x55, 0x41, 0x49, 0x4A -> - = , . / (shifted _ + < > ?).
REQ-022 Unmapped make codes SHALL produce no k_valid.
REQ-023 Repeated make codes (typematic) SHALL emit once per received make byte.
REQ-024 A frame error SHALL return the FSM to IDLE; shift state is kept.
REQ-025 key_out SHALL hold its value between k_valid pulses.
REQ-026 At most one byte SHALL be decoded per cycle; k_valid SHALL never be high on two consecutive cycles.

Reset
REQ-027 Reset SHALL clear key_out=0x00, k_valid=0, frame_err=0, shift_active=0, bit count, timeout counter and shift register, and force FSM to IDLE, including mid-frame or mid-prefix.
REQ-028 Synchroniser flops SHALL reset to 1 (bus idle level).

Structure
REQ-029 Shared package ps2_pkg SHALL hold FSM state typedef, prefix constants (F0, E0), shift codes (0x12, 0x59) and ASCII constants ENTER=0x0A, BS=0x08, SPACE=0x20.
REQ-030 Frame reception (sync, edge detect, shift, parity, timeout) SHALL be sub-module ps2_rx; ps2_key_ascii holds the FSM and translation table.

Verification
REQ-031 Frame 0x1C, then F0, 1C -> one k_valid, key_out=0x61; no pulse for the break.
REQ-032 12, 1C, F0 1C, F0 12, 1C -> pulses 0x41 then 0x61; shift_active high only between 12 and F0 12.
REQ-033 5A -> 0x0A; E0 5A -> 0x0A; E0 F0 5A -> no pulse; 16 with shift -> 0x21.
REQ-034 1C with even parity -> frame_err one cycle, no k_valid; following good 1C -> 0x61.
REQ-035 5 bits then idle TIMEOUT_CYCLES+2 -> frame_err pulse; next full 0x32 frame -> 0x62.
REQ-036 Reset asserted after F0 received, then 1C -> 0x61 emitted (break prefix cleared).

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard-to-ASCII path: decoder states,
// scan-code prefixes, shift-key codes, control ASCII values and frame checks.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } dec_state_t;

    // Scan-code prefixes (set 2)
    localparam logic [7:0] CODE_BREAK  = 8'hF0;
    localparam logic [7:0] CODE_EXT    = 8'hE0;

    // Shift keys and the one extended key we translate
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_RSHIFT = 8'h59;
    localparam logic [7:0] CODE_ENTER  = 8'h5A;

    // ASCII control values
    localparam logic [7:0] ENTER       = 8'h0A;
    localparam logic [7:0] BS          = 8'h08;
    localparam logic [7:0] SPACE       = 8'h20;
    localparam logic [7:0] ASCII_NUL   = 8'h00;

    // Start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    // Odd parity holds when data bits plus parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return (^data) ^ parity;
    endfunction

    // Either shift key (left or right).
    function automatic logic is_shift_code(input logic [7:0] code);
        return (code == CODE_LSHIFT) || (code == CODE_RSHIFT);
    endfunction

endpackage

// File: rtl/ps2_key_ascii_if.sv
// Bundle of the PS/2 line inputs and the key stream toward display memory.
// The master side is the decoder; the slave side is keyboard/consumer.
interface ps2_key_ascii_if;

    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] key_out;
    logic       k_valid;
    logic       frame_err;
    logic       shift_active;

    modport master (
        input  ps2_clk,
        input  ps2_data,
        output key_out,
        output k_valid,
        output frame_err,
        output shift_active
    );

    modport slave (
        output ps2_clk,
        output ps2_data,
        input  key_out,
        input  k_valid,
        input  frame_err,
        input  shift_active
    );

endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronises the raw lines, detects ps2_clk falling
// edges, assembles 11-bit frames, checks start/parity/stop and aborts frames
// that stall. Emits a one-cycle byte strobe the cycle after the stop-bit edge.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] data_sync_r;
    logic                   clk_prev_r;
    logic [3:0]             bit_cnt_r;
    logic [9:0]             shift_r;
    logic [TMO_W-1:0]       tmo_cnt_r;
    logic [7:0]             byte_r;
    logic                   byte_valid_r;
    logic                   frame_err_r;

    logic                   fall_s;
    logic                   data_s;
    logic [10:0]            frame_s;
    logic                   last_bit_s;
    logic                   frame_ok_s;
    logic                   tmo_hit_s;

    // Synchronise both PS/2 lines; everything resets to the idle-high level so no false edge appears.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_r  <= '1;
            data_sync_r <= '1;
            clk_prev_r  <= 1'b1;
        end else begin
            clk_sync_r[0]  <= ps2_clk;
            data_sync_r[0] <= ps2_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                clk_sync_r[i]  <= clk_sync_r[i-1];
                data_sync_r[i] <= data_sync_r[i-1];
            end
            clk_prev_r <= clk_sync_r[SYNC_STAGES-1];
        end
    end

    // Edge detect, frame assembly with the incoming bit, and validity checks.
    always_comb begin
        fall_s     = clk_prev_r & ~clk_sync_r[SYNC_STAGES-1];
        data_s     = data_sync_r[SYNC_STAGES-1];
        frame_s    = {data_s, shift_r};
        last_bit_s = (bit_cnt_r == LAST_BIT);
        frame_ok_s = (frame_s[0] == 1'b0) && (frame_s[10] == 1'b1)
                     && odd_parity_ok(frame_s[8:1], frame_s[9]);
        tmo_hit_s  = (bit_cnt_r != 4'd0) && (tmo_cnt_r == TMO_LAST);
    end

    // Bit counter, shift register, stall timeout and the registered byte/error strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_r    <= 4'd0;
            shift_r      <= 10'd0;
            tmo_cnt_r    <= '0;
            byte_r       <= 8'h00;
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            byte_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            if (fall_s) begin
                tmo_cnt_r <= '0;
                if (last_bit_s) begin
                    bit_cnt_r <= 4'd0;
                    shift_r   <= 10'd0;
                    if (frame_ok_s) begin
                        byte_r       <= frame_s[8:1];
                        byte_valid_r <= 1'b1;
                    end else begin
                        frame_err_r <= 1'b1;
                    end
                end else begin
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                    shift_r   <= frame_s[10:1];
                end
            end else if (tmo_hit_s) begin
                // Keyboard stopped mid-frame: drop what we have and resynchronise.
                bit_cnt_r   <= 4'd0;
                shift_r     <= 10'd0;
                tmo_cnt_r   <= '0;
                frame_err_r <= 1'b1;
            end else if (bit_cnt_r != 4'd0) begin
                tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
            end else begin
                tmo_cnt_r <= '0;
            end
        end
    end

    assign byte_out   = byte_r;
    assign byte_valid = byte_valid_r;
    assign frame_err  = frame_err_r;

endmodule

// File: rtl/ps2_key_ascii.sv
// PS/2 set-2 scan code to ASCII converter. Tracks break/extended prefixes and
// shift state, translates make codes (US layout) and emits registered
// key_out/k_valid two cycles after the stop bit.
module ps2_key_ascii
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clk,
    input  logic             reset,
    ps2_key_ascii_if.master  bus
);

    logic [7:0] rx_byte_s;
    logic       rx_valid_s;
    logic       rx_err_s;

    dec_state_t state_r;
    dec_state_t state_n;
    logic       shift_r;
    logic       shift_n;
    logic       emit_s;
    logic [7:0] emit_key_s;
    logic [8:0] xlat_s;

    logic [7:0] key_out_r;
    logic       k_valid_r;
    logic       frame_err_r;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (bus.ps2_clk),
        .ps2_data   (bus.ps2_data),
        .byte_out   (rx_byte_s),
        .byte_valid (rx_valid_s),
        .frame_err  (rx_err_s)
    );

    // US-layout make-code translation; returns {mapped, ascii}.
    function automatic logic [8:0] translate(input logic [7:0] code, input logic shift);
        logic [7:0] base;
        logic [7:0] alt;
        logic       mapped;
        base   = 8'h00;
        alt    = 8'h00;
        mapped = 1'b1;
        case (code)
            // Letters: only the lowercase value is listed, uppercase derived below
            8'h1C: base = 8'h61;  8'h32: base = 8'h62;  8'h21: base = 8'h63;
            8'h23: base = 8'h64;  8'h24: base = 8'h65;  8'h2B: base = 8'h66;
            8'h34: base = 8'h67;  8'h33: base = 8'h68;  8'h43: base = 8'h69;
            8'h3B: base = 8'h6A;  8'h42: base = 8'h6B;  8'h4B: base = 8'h6C;
            8'h3A: base = 8'h6D;  8'h31: base = 8'h6E;  8'h44: base = 8'h6F;
            8'h4D: base = 8'h70;  8'h15: base = 8'h71;  8'h2D: base = 8'h72;
            8'h1B: base = 8'h73;  8'h2C: base = 8'h74;  8'h3C: base = 8'h75;
            8'h2A: base = 8'h76;  8'h1D: base = 8'h77;  8'h22: base = 8'h78;
            8'h35: base = 8'h79;  8'h1A: base = 8'h7A;
            // Digit row
            8'h16: begin base = 8'h31; alt = 8'h21; end
            8'h1E: begin base = 8'h32; alt = 8'h40; end
            8'h26: begin base = 8'h33; alt = 8'h23; end
            8'h25: begin base = 8'h34; alt = 8'h24; end
            8'h2E: begin base = 8'h35; alt = 8'h25; end
            8'h36: begin base = 8'h36; alt = 8'h5E; end
            8'h3D: begin base = 8'h37; alt = 8'h26; end
            8'h3E: begin base = 8'h38; alt = 8'h2A; end
            8'h46: begin base = 8'h39; alt = 8'h28; end
            8'h45: begin base = 8'h30; alt = 8'h29; end
            // Punctuation
            8'h4E: begin base = 8'h2D; alt = 8'h5F; end
            8'h55: begin base = 8'h3D; alt = 8'h2B; end
            8'h41: begin base = 8'h2C; alt = 8'h3C; end
            8'h49: begin base = 8'h2E; alt = 8'h3E; end
            8'h4A: begin base = 8'h2F; alt = 8'h3F; end
            // Shift-insensitive keys
            8'h29: begin base = SPACE; alt = SPACE; end
            CODE_ENTER: begin base = ENTER; alt = ENTER; end
            8'h66: begin base = BS;    alt = BS;    end
            default: mapped = 1'b0;
        endcase
        if ((base >= 8'h61) && (base <= 8'h7A)) begin
            alt = base - 8'h20;
        end else begin
            alt = alt;
        end
        return {mapped, (shift ? alt : base)};
    endfunction

    // Decoder next-state, shift tracking and emission decision for each received byte.
    always_comb begin
        state_n    = state_r;
        shift_n    = shift_r;
        emit_s     = 1'b0;
        emit_key_s = ASCII_NUL;
        xlat_s     = translate(rx_byte_s, shift_r);
        if (rx_err_s) begin
            // A corrupted byte may have been a prefix; forget any pending prefix but keep shift.
            state_n = IDLE;
        end else if (rx_valid_s) begin
            case (state_r)
                IDLE: begin
                    if (rx_byte_s == CODE_BREAK) begin
                        state_n = BRK;
                    end else if (rx_byte_s == CODE_EXT) begin
                        state_n = EXT;
                    end else if (is_shift_code(rx_byte_s)) begin
                        shift_n = 1'b1;
                    end else begin
                        emit_s     = xlat_s[8];
                        emit_key_s = xlat_s[7:0];
                    end
                end
                BRK: begin
                    state_n = IDLE;
                    if (is_shift_code(rx_byte_s)) begin
                        shift_n = 1'b0;
                    end else begin
                        shift_n = shift_r;
                    end
                end
                EXT: begin
                    if (rx_byte_s == CODE_BREAK) begin
                        state_n = EXT_BRK;
                    end else if (rx_byte_s == CODE_ENTER) begin
                        state_n    = IDLE;
                        emit_s     = 1'b1;
                        emit_key_s = ENTER;
                    end else begin
                        state_n = IDLE;
                    end
                end
                EXT_BRK: state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // Decoder state and shift register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            shift_r <= 1'b0;
        end else begin
            state_r <= state_n;
            shift_r <= shift_n;
        end
    end

    // Registered outputs; key_out holds its last value between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_out_r   <= ASCII_NUL;
            k_valid_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            k_valid_r   <= emit_s;
            frame_err_r <= rx_err_s;
            if (emit_s) begin
                key_out_r <= emit_key_s;
            end else begin
                key_out_r <= key_out_r;
            end
        end
    end

    assign bus.key_out      = key_out_r;
    assign bus.k_valid      = k_valid_r;
    assign bus.frame_err    = frame_err_r;
    assign bus.shift_active = shift_r;

endmodule
